io_controller: RTL

- Memory-mapped-less I/O stage directly downstream of the pipeline core's I/O port; consumes out_issued/out_data/in_issued and produces out_stall/in_stall/in_data/status.
- Buffers bytes between the core and byte-level UART tx/rx engines with one TX FIFO and one RX FIFO.
- Stall outputs let the core hold an I/O instruction until the FIFO can serve it.

---
 rtl/io_pkg.sv | 19 +
 rtl/io_controller_sync_fifo.sv | 64 ++++++
 rtl/io_controller.sv | 125 ++++++++++++
 3 files changed

// File: rtl/io_pkg.sv
// io_pkg: shared constants for the I/O controller -- status word bit layout
// and default FIFO depths.
package io_pkg;

  // Status word single-bit flag positions
  localparam int STAT_RX_NONEMPTY = 0;
  localparam int STAT_TX_FULL     = 1;
  localparam int STAT_RX_OVF      = 2;
  localparam int STAT_TX_EMPTY    = 3;

  // Status word count-field LSB positions (each field is 8 bits wide)
  localparam int STAT_RX_CNT_LSB  = 8;
  localparam int STAT_TX_CNT_LSB  = 16;

  // Default FIFO depths, as log2 of the entry count
  localparam int DEFAULT_TX_DEPTH_LOG2 = 4;
  localparam int DEFAULT_RX_DEPTH_LOG2 = 4;

endpackage

// File: rtl/io_controller_sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO with a registered count and
// registered full/empty flags. The caller only asserts push when there is
// room (or a pop happens in the same cycle), and only asserts pop when the
// FIFO is not empty; the FIFO itself does not re-check either condition.
module sync_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      head,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count_next;

  // Head is read straight out of storage so a freshly written entry is
  // visible as soon as empty drops.
  assign head = mem[rd_ptr];

  // Next occupancy from this cycle's push/pop pair
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Storage write; contents are don't-care while the entry is not live
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointers, count and the registered flags; pointers wrap modulo depth
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == DEPTH_CNT);
      empty <= (count_next == '0);
    end
  end

endmodule

// File: rtl/io_controller.sv
// io_controller: byte buffering between the pipeline core's I/O port and the
// UART tx/rx engines, using one TX FIFO and one RX FIFO.
// Optional build macro IO_LOOPBACK_EN routes TX FIFO output back into the
// RX FIFO instead of the UART.
//
// Handshakes:
//   core out : a byte is pushed on a cycle with out_issued && !out_stall.
//   core in  : a byte is popped on a cycle with in_issued && !in_stall;
//              in_data carries the head byte while in_stall is low.
//   uart tx  : a byte is transferred on a cycle with tx_valid && tx_ready;
//              tx_data is stable while tx_valid is high and not yet accepted.
//   uart rx  : rx_valid is a one-cycle strobe with no backpressure; a byte
//              that arrives while the RX FIFO is full and nothing pops it
//              is dropped and latches rx_overflow.
module io_controller
  import io_pkg::*;
#(
  parameter int TX_DEPTH_LOG2 = DEFAULT_TX_DEPTH_LOG2,
  parameter int RX_DEPTH_LOG2 = DEFAULT_RX_DEPTH_LOG2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        out_issued,
  input  logic [31:0] out_data,
  output logic        out_stall,
  input  logic        in_issued,
  output logic [31:0] in_data,
  output logic        in_stall,
  output logic [31:0] status,
  input  logic        ovf_clr,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid
);

  logic                 tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]           tx_head;
  logic [TX_DEPTH_LOG2:0] tx_count;

  logic                 rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]           rx_head, rx_push_data;
  logic [RX_DEPTH_LOG2:0] rx_count;

  logic                 rx_overflow;
  logic                 ovf_event;

  // Only the low byte of an out request is transmitted
  logic unused_out_hi;
  assign unused_out_hi = ^out_data[31:8];

  // Core side: out_stall/in_stall are the registered FIFO flags, so a pop
  // in the same cycle never unblocks a push into a full TX FIFO.
  assign tx_push   = out_issued && !tx_full;
  assign rx_pop    = in_issued && !rx_empty;
  assign out_stall = tx_full;
  assign in_stall  = rx_empty;
  assign in_data   = rx_empty ? 32'h0 : {24'h0, rx_head};

`ifdef IO_LOOPBACK_EN
  // UART inputs are ignored while looping back
  logic unused_uart_in;
  assign unused_uart_in = ^{tx_ready, rx_data, rx_valid};

  // TX head drains into RX whenever RX has room, so nothing is ever dropped
  assign tx_pop       = !tx_empty && !rx_full;
  assign rx_push      = tx_pop;
  assign rx_push_data = tx_head;
  assign ovf_event    = 1'b0;
  assign tx_valid     = 1'b0;
  assign tx_data      = 8'h00;
`else
  // UART side: FIFO head drives the transmitter; the receiver pushes blindly
  assign tx_valid     = !tx_empty;
  assign tx_data      = tx_empty ? 8'h00 : tx_head;
  assign tx_pop       = tx_valid && tx_ready;
  assign ovf_event    = rx_valid && rx_full && !rx_pop;
  assign rx_push      = rx_valid && !ovf_event;
  assign rx_push_data = rx_data;
`endif

  sync_fifo #(.DEPTH_LOG2(TX_DEPTH_LOG2), .WIDTH(8)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tx_push),
    .push_data (out_data[7:0]),
    .pop       (tx_pop),
    .head      (tx_head),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count)
  );

  sync_fifo #(.DEPTH_LOG2(RX_DEPTH_LOG2), .WIDTH(8)) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_push),
    .push_data (rx_push_data),
    .pop       (rx_pop),
    .head      (rx_head),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count)
  );

  // Sticky overflow flag; a new overflow wins over a coincident clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           rx_overflow <= 1'b0;
    else if (ovf_event) rx_overflow <= 1'b1;
    else if (ovf_clr)   rx_overflow <= 1'b0;
  end

  // Status word assembly; unlisted bits stay zero
  always_comb begin
    status = 32'h0;
    status[STAT_RX_NONEMPTY]         = !rx_empty;
    status[STAT_TX_FULL]             = tx_full;
    status[STAT_RX_OVF]              = rx_overflow;
    status[STAT_TX_EMPTY]            = tx_empty;
    status[STAT_RX_CNT_LSB +: 8]     = 8'(rx_count);
    status[STAT_TX_CNT_LSB +: 8]     = 8'(tx_count);
  end

endmodule
